// File: rtl/div_restoring_16_pkg.sv
// Shared constants and state encoding for the 16-bit restoring divider.
package div_restoring_16_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } div_state_e;

  localparam int unsigned Iter        = 16;
  localparam logic [15:0] DbzQuotient = 16'hFFFF;

endpackage

// File: rtl/div_restoring_16_if.sv
// Request/result bundle between a requester (master) and the divider (slave).
interface div_restoring_16_if;

  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/div_restoring_16_addsub.sv
// 16-bit adder/subtractor: S = X + Y (Sub=0) or X - Y (Sub=1); Cout=1 means no borrow when
// subtracting.
module ADDSUB_16 (
  input  logic [15:0] X,
  input  logic [15:0] Y,
  input  logic        Sub,
  output logic [15:0] S,
  output logic        Cout
);

  logic [15:0] y_eff;

  always_comb begin
    y_eff     = Y ^ {16{Sub}};
    {Cout, S} = {1'b0, X} + {1'b0, y_eff} + {16'b0, Sub};
  end

endmodule

// File: rtl/div_restoring_16.sv
// Sequential unsigned 16/16 restoring divider, one trial subtraction per cycle.
module div_restoring_16
  import div_restoring_16_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  div_restoring_16_if.slave   bus
);

  div_state_e  state_q, state_d;
  logic [15:0] r_q, r_d;
  logic [15:0] q_q, q_d;
  logic [15:0] d_q, d_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] quotient_q, quotient_d;
  logic [15:0] remainder_q, remainder_d;
  logic        dbz_q, dbz_d;

  logic [16:0] t;
  logic [15:0] diff;
  logic        no_borrow;
  logic        ge;
  logic [15:0] r_next;
  logic [15:0] q_next;

  assign t = {r_q, q_q[15]};

  ADDSUB_16 u_addsub (
    .X    (t[15:0]),
    .Y    (d_q),
    .Sub  (1'b1),
    .S    (diff),
    .Cout (no_borrow)
  );

  // t[16] set means t >= 2^16 > d, so the subtraction fits even when the 16-bit trial borrows.
  assign ge     = t[16] | no_borrow;
  assign r_next = ge ? diff : t[15:0];
  assign q_next = {q_q[14:0], ge};

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    q_d         = q_q;
    d_d         = d_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (bus.divisor == 16'd0) begin
            quotient_d  = DbzQuotient;
            remainder_d = bus.dividend;
            dbz_d       = 1'b1;
            state_d     = StDone;
          end else begin
            r_d     = 16'd0;
            q_d     = bus.dividend;
            d_d     = bus.divisor;
            cnt_d   = 5'd0;
            state_d = StRun;
          end
        end
      end
      StRun: begin
        r_d   = r_next;
        q_d   = q_next;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(Iter - 1)) begin
          quotient_d  = q_next;
          remainder_d = r_next;
          dbz_d       = 1'b0;
          state_d     = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      r_q         <= 16'd0;
      q_q         <= 16'd0;
      d_q         <= 16'd0;
      cnt_q       <= 5'd0;
      quotient_q  <= 16'd0;
      remainder_q <= 16'd0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      q_q         <= q_d;
      d_q         <= d_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign bus.busy        = (state_q != StIdle);
  assign bus.done        = (state_q == StDone);
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_restoring_16.sv
// Directed-vector bench for div_restoring_16 with hand-computed results and latencies.
module tb_div_restoring_16;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  div_restoring_16_if bus ();

  div_restoring_16 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issues a start at the next edge, then follows the operation cycle by cycle until done.
  task automatic run_div(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp_q, input logic [15:0] exp_r,
                         input logic exp_dbz, input int exp_cyc, input int poke);
    int   cyc;
    logic seen;
    logic busy_ok;
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc       = 1;
    seen      = 1'b0;
    busy_ok   = 1'b1;
    while (cyc <= 40 && !seen) begin
      if (bus.done === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (bus.busy !== 1'b1) busy_ok = 1'b0;
        if (cyc == poke) begin
          bus.start    = 1'b1;
          bus.dividend = 16'd50;
          bus.divisor  = 16'd5;
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc++;
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_done_cycle"}, 32'(cyc), 32'(exp_cyc));
    check({tag, "_busy_run"}, 32'(busy_ok), 32'd1);
    check({tag, "_busy_done"}, 32'(bus.busy), 32'd1);
    check({tag, "_quotient"}, 32'(bus.quotient), 32'(exp_q));
    check({tag, "_remainder"}, 32'(bus.remainder), 32'(exp_r));
    check({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(exp_dbz));
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    check({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_q_held"}, 32'(bus.quotient), 32'(exp_q));
  endtask

  initial begin
    logic stray_done;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = 16'd0;
    bus.divisor  = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_quotient", 32'(bus.quotient), 32'd0);
    check("rst_remainder", 32'(bus.remainder), 32'd0);
    check("rst_dbz", 32'(bus.div_by_zero), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_div("d100_7", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 17, 0);
    run_div("ffff_8001", 16'hFFFF, 16'h8001, 16'd1, 16'h7FFE, 1'b0, 17, 0);
    run_div("d5_10", 16'd5, 16'd10, 16'd0, 16'd5, 1'b0, 17, 0);
    run_div("ffff_1", 16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, 17, 0);
    run_div("dbz", 16'h1234, 16'd0, 16'hFFFF, 16'h1234, 1'b1, 1, 0);
    run_div("d9_3", 16'd9, 16'd3, 16'd3, 16'd0, 1'b0, 17, 0);
    run_div("ignored_start", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 17, 5);

    // Abort a division in cycle 8 with reset.
    bus.start    = 1'b1;
    bus.dividend = 16'd100;
    bus.divisor  = 16'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (7) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_quotient", 32'(bus.quotient), 32'd0);
    check("abort_remainder", 32'(bus.remainder), 32'd0);
    check("abort_dbz", 32'(bus.div_by_zero), 32'd0);
    stray_done = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) stray_done = 1'b1;
    end
    check("abort_no_done", 32'(stray_done), 32'd0);

    run_div("d20_6", 16'd20, 16'd6, 16'd3, 16'd2, 1'b0, 17, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
